// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one single-port SRAM between two requesters:
//   A - key expansion engine
//   B - AES round datapath
//
// Each transaction takes three cycles: IDLE (arbitrate) -> ACCESS (one SRAM
// strobe) -> DONE (one-cycle ack). Simultaneous requests are resolved
// round-robin. After reset, A wins the first tie.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   a_req/a_write/a_addr/a_wdata   requester A command (req held until ack)
//   a_ack, a_rdata                 requester A completion pulse / read data
//   b_*                            same as A, for requester B
//   sram_read, sram_write          SRAM strobes (never both high)
//   sram_addr, sram_wdata          SRAM address / write data (held outside ACCESS)
//   sram_rdata                     SRAM read data, combinational from address
//   busy                           high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,

  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // FSM and arbitration state
  state_t              r_state;
  req_id_t             r_last_grant;
  req_id_t             r_grant_id;

  // Command latched at grant time
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // Per-requester read data
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;

  // Registered output strobes
  logic                r_a_ack;
  logic                r_b_ack;
  logic                r_sram_read;
  logic                r_sram_write;
  logic                r_busy;

  // Arbitration result for the current IDLE cycle
  logic                w_grant_valid;
  req_id_t             w_grant_id;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_grant_valid = a_req | b_req;

  // Round-robin: on a tie, grant whichever requester was not granted last.
  always_comb begin
    w_grant_id = REQ_A;
    if (a_req && b_req) begin
      w_grant_id = (r_last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (b_req) begin
      w_grant_id = REQ_B;
    end
  end

  always_comb begin
    w_sel_write = a_write;
    w_sel_addr  = a_addr;
    w_sel_wdata = a_wdata;
    if (w_grant_id == REQ_B) begin
      w_sel_write = b_write;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ_B;
      r_grant_id   <= REQ_A;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_sram_read  <= 1'b0;
      r_sram_write <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          if (w_grant_valid) begin
            r_state      <= ST_ACCESS;
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_write      <= w_sel_write;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_sram_read  <= ~w_sel_write;
            r_sram_write <= w_sel_write;
            r_busy       <= 1'b1;
          end
        end

        ST_ACCESS: begin
          r_state      <= ST_DONE;
          r_sram_read  <= 1'b0;
          r_sram_write <= 1'b0;
          // SRAM read data is combinational, so it is valid at the end of ACCESS.
          if (!r_write) begin
            if (r_grant_id == REQ_A) begin
              r_a_rdata <= sram_rdata;
            end else begin
              r_b_rdata <= sram_rdata;
            end
          end
          r_a_ack <= (r_grant_id == REQ_A);
          r_b_ack <= (r_grant_id == REQ_B);
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_a_ack      <= 1'b0;
          r_b_ack      <= 1'b0;
          r_sram_read  <= 1'b0;
          r_sram_write <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are registered, but they are also forced quiet while rst is high.
  // This lets a reset that lands in ACCESS suppress the strobe in that same
  // cycle, so an aborted write never reaches the SRAM.
  assign sram_read  = r_sram_read  & ~rst;
  assign sram_write = r_sram_write & ~rst;
  assign sram_addr  = rst ? '0 : r_addr;
  assign sram_wdata = rst ? '0 : r_wdata;
  assign a_ack      = r_a_ack & ~rst;
  assign b_ack      = r_b_ack & ~rst;
  assign busy       = r_busy  & ~rst;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed testbench for sram_arbiter. It includes a small behavioural SRAM
// (256 words, indexed by the low address byte) that is preloaded with
// {16{addr[7:0]}} while the bench's init flag is set.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int AW = 16;
  localparam int DW = 128;

  localparam logic [DW-1:0] D_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] D_B = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [DW-1:0] D_F = 128'hDEADBEEFCAFEF00DDEADBEEFCAFEF00D;

  logic          clk;
  logic          rst;
  logic          a_req, a_write, a_ack;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_write, b_ack;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          sram_read, sram_write, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic          tb_init;
  logic [DW-1:0] mem [256];
  logic          prev_strobe;

  int            n_tests;
  int            n_fail;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_req      (a_req),
    .a_write    (a_write),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_write    (b_write),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int k = 0; k < 256; k++) begin
        mem[k] <= {16{k[7:0]}};
      end
    end else if (sram_write) begin
      mem[sram_addr[7:0]] <= sram_wdata;
    end
  end
  assign sram_rdata = mem[sram_addr[7:0]];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks that hold in every cycle.
  always @(negedge clk) begin
    if (!tb_init) begin
      check("strobe_excl", 128'(sram_read && sram_write), 128'(0));
      check("ack_excl", 128'(a_ack && b_ack), 128'(0));
      check("ack_only_done", 128'((a_ack || b_ack) && !prev_strobe), 128'(0));
    end
    prev_strobe <= sram_read || sram_write;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   128'(busy),       128'(0));
    check({tag, "_a_ack"},  128'(a_ack),      128'(0));
    check({tag, "_b_ack"},  128'(b_ack),      128'(0));
    check({tag, "_rd"},     128'(sram_read),  128'(0));
    check({tag, "_wr"},     128'(sram_write), 128'(0));
    check({tag, "_addr"},   128'(sram_addr),  128'(0));
    check({tag, "_wdata"},  sram_wdata,       128'(0));
    check({tag, "_a_rdata"}, a_rdata,         128'(0));
    check({tag, "_b_rdata"}, b_rdata,         128'(0));
  endtask

  logic       order [5];
  int         na, nb, nack, a_lat;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    prev_strobe = 1'b0;
    tb_init = 1'b1;
    rst = 1'b1;
    a_req = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset state: during reset and in the cycle after it
    tick(); tick();
    check_quiet("rst_in");
    tb_init = 1'b0;
    rst = 1'b0;
    tick();
    check_quiet("rst_after");

    // A writes 0x0010, then reads it back
    a_req = 1'b1; a_write = 1'b1; a_addr = 16'h0010; a_wdata = D_A;
    tick();
    check("wr_strobe", 128'(sram_write), 128'(1));
    check("wr_nord",   128'(sram_read),  128'(0));
    check("wr_addr",   128'(sram_addr),  128'(16'h0010));
    check("wr_wdata",  sram_wdata,       D_A);
    check("wr_busy",   128'(busy),       128'(1));
    check("wr_noack",  128'(a_ack),      128'(0));
    tick();
    check("wr_ack",    128'(a_ack),      128'(1));
    check("wr_back",   128'(b_ack),      128'(0));
    check("wr_once",   128'(sram_write), 128'(0));
    check("wr_rdata",  a_rdata,          128'(0));
    a_req = 1'b0;
    tick();
    check("wr_idle_ack",  128'(a_ack),     128'(0));
    check("wr_idle_busy", 128'(busy),      128'(0));
    check("wr_addr_hold", 128'(sram_addr), 128'(16'h0010));
    a_req = 1'b1; a_write = 1'b0;
    tick();
    check("rd_strobe", 128'(sram_read),  128'(1));
    check("rd_nowr",   128'(sram_write), 128'(0));
    check("rd_addr",   128'(sram_addr),  128'(16'h0010));
    tick();
    check("rd_ack",    128'(a_ack),      128'(1));
    check("rd_data",   a_rdata,          D_A);
    a_req = 1'b0;
    tick();
    check("rd_ack_end", 128'(a_ack),     128'(0));
    check("rd_hold",    a_rdata,         D_A);

    // Simultaneous requests after reset: A first; A re-requests at once, so B wins next
    rst = 1'b1; tick(); rst = 1'b0; tick();
    a_req = 1'b1; a_write = 1'b0; a_addr = 16'h0010;
    b_req = 1'b1; b_write = 1'b1; b_addr = 16'h0020; b_wdata = D_B;
    tick();
    check("rr1_rd",   128'(sram_read), 128'(1));
    check("rr1_addr", 128'(sram_addr), 128'(16'h0010));
    tick();
    check("rr1_aack", 128'(a_ack),  128'(1));
    check("rr1_back", 128'(b_ack),  128'(0));
    check("rr1_data", a_rdata,      D_A);
    a_addr = 16'h0020;
    tick();
    check("rr1_idle", 128'(busy),   128'(0));
    tick();
    check("rr2_wr",    128'(sram_write), 128'(1));
    check("rr2_addr",  128'(sram_addr),  128'(16'h0020));
    check("rr2_wdata", sram_wdata,       D_B);
    tick();
    check("rr2_back", 128'(b_ack),  128'(1));
    check("rr2_aack", 128'(a_ack),  128'(0));
    b_req = 1'b0;
    tick();
    tick();
    check("rr3_rd",   128'(sram_read), 128'(1));
    check("rr3_addr", 128'(sram_addr), 128'(16'h0020));
    tick();
    check("rr3_aack", 128'(a_ack),  128'(1));
    check("rr3_data", a_rdata,      D_B);
    a_req = 1'b0;
    tick();

    // B holds its request for four transactions while A requests once
    b_req = 1'b1; b_write = 1'b0; b_addr = 16'h0010;
    tick();
    a_req = 1'b1; a_write = 1'b0; a_addr = 16'h0020;
    na = 0; nb = 0; nack = 0; a_lat = 0;
    for (int i = 1; i <= 30 && !(nb == 4 && na == 1); i++) begin
      tick();
      if (a_ack) begin
        if (nack < 5) order[nack] = 1'b0;
        nack++; na++; a_lat = i;
        check("starve_adata", a_rdata, D_B);
        a_req = 1'b0;
      end
      if (b_ack) begin
        if (nack < 5) order[nack] = 1'b1;
        nack++; nb++;
        check("starve_bdata", b_rdata, D_A);
        if (nb == 4) b_req = 1'b0;
      end
    end
    check("starve_na",  128'(na),    128'(1));
    check("starve_nb",  128'(nb),    128'(4));
    check("starve_lat", 128'(a_lat), 128'(4));
    check("order", 128'({order[0], order[1], order[2], order[3], order[4]}), 128'(5'b10111));
    tick();
    check("starve_idle", 128'(busy), 128'(0));

    // A address changes after grant are ignored
    a_req = 1'b1; a_write = 1'b0; a_addr = 16'h0001;
    tick();
    check("lat_rd",    128'(sram_read), 128'(1));
    check("lat_addr0", 128'(sram_addr), 128'(16'h0001));
    a_addr = 16'h0002;
    #2;
    check("lat_addr1", 128'(sram_addr), 128'(16'h0001));
    tick();
    check("lat_ack",   128'(a_ack),     128'(1));
    check("lat_data",  a_rdata,         {16{8'h01}});
    check("lat_addr2", 128'(sram_addr), 128'(16'h0001));
    a_req = 1'b0;
    tick();

    // Reset during the ACCESS cycle of a write aborts it
    a_req = 1'b1; a_write = 1'b1; a_addr = 16'h0030; a_wdata = D_F;
    tick();
    check("ab_wr", 128'(sram_write), 128'(1));
    rst = 1'b1;
    #1;
    check("ab_wr_gated", 128'(sram_write), 128'(0));
    check("ab_busy_rst", 128'(busy),       128'(0));
    check("ab_addr_rst", 128'(sram_addr),  128'(0));
    tick();
    check("ab_ack",    128'(a_ack), 128'(0));
    check("ab_busy",   128'(busy),  128'(0));
    check("ab_rdata",  a_rdata,     128'(0));
    rst = 1'b0; a_req = 1'b0;
    tick();
    check("ab_ack2",   128'(a_ack), 128'(0));
    check("ab_busy2",  128'(busy),  128'(0));
    a_req = 1'b1; a_write = 1'b0; a_addr = 16'h0030;
    tick();
    tick();
    check("ab_rd_ack",  128'(a_ack), 128'(1));
    check("ab_rd_data", a_rdata,     {16{8'h30}});
    a_req = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
